// File: rtl/pwm_ramp_sequencer.sv
// Soft-start/soft-stop sequencer feeding the PWM generator's period/duty/burst inputs.
// Duty ramps in fixed steps on PWM period boundaries, holds, then ramps back to zero.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start, duty 0, period counter parked
// RAMP_UP   | duty rises by step every periods_per_step PWM periods
// HOLD      | duty at target, burst configuration driven
// RAMP_DOWN | duty falls by step until 0, then done pulse and IDLE
module pwm_ramp_sequencer #(
    parameter int PERIOD_W   = 16,
    parameter int DUTY_MAX   = 100,
    parameter int MIN_PERIOD = 2
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [7:0]          target_duty,
    input  logic [7:0]          step,
    input  logic [7:0]          periods_per_step,
    input  logic                burst_req,
    input  logic                burst_type_in,
    output logic [PERIOD_W-1:0] period_out,
    output logic [7:0]          duty_out,
    output logic                burstmode_out,
    output logic                bursttype_out,
    output logic                busy,
    output logic                holding,
    output logic                done
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [7:0]          DMAX  = 8'(DUTY_MAX);

    logic [1:0]          state, state_nxt;
    logic [PERIOD_W-1:0] pcnt;
    logic [7:0]          scnt;
    logic [7:0]          target_r, step_r, pps_r;
    logic                burst_r;
    logic                accept, tick, step_ev;
    logic [7:0]          duty_nxt;
    logic                done_nxt;
    logic [8:0]          up_sum;
    logic [7:0]          up_duty, dn_duty;
    logic [PERIOD_W-1:0] period_lat;
    logic [7:0]          target_lat;

    assign accept     = (state == ST_IDLE) && start && !stop;
    assign period_lat = (period_in < MIN_P) ? MIN_P : period_in;
    assign target_lat = (target_duty > DMAX) ? DMAX : target_duty;

    assign tick    = (state != ST_IDLE) && (pcnt == period_out - PERIOD_W'(1));
    assign step_ev = tick && (scnt == pps_r - 8'd1);

    // 9-bit sum so a large step near the top cannot wrap before the clamp
    assign up_sum  = {1'b0, duty_out} + {1'b0, step_r};
    assign up_duty = (up_sum > {1'b0, target_r}) ? target_r : up_sum[7:0];
    assign dn_duty = (duty_out > step_r) ? (duty_out - step_r) : 8'd0;

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_out;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = (target_lat == 8'd0) ? ST_HOLD : ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (stop) begin
                    state_nxt = ST_RAMP_DOWN;
                end else if (step_ev) begin
                    duty_nxt = up_duty;
                    if (up_duty == target_r)
                        state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (stop)
                    state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (duty_out == 8'd0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (step_ev) begin
                    duty_nxt = dn_duty;
                    if (dn_duty == 8'd0) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            duty_out      <= 8'd0;
            done          <= 1'b0;
            period_out    <= MIN_P;
            target_r      <= 8'd0;
            step_r        <= 8'd0;
            pps_r         <= 8'd0;
            burst_r       <= 1'b0;
            bursttype_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty_out <= duty_nxt;
            done     <= done_nxt;
            if (accept) begin
                period_out    <= period_lat;
                target_r      <= target_lat;
                step_r        <= (step == 8'd0) ? 8'd1 : step;
                pps_r         <= (periods_per_step == 8'd0) ? 8'd1 : periods_per_step;
                burst_r       <= burst_req;
                bursttype_out <= burst_type_in;
            end
        end
    end

    // pcnt is parked at 0 in IDLE, so RAMP_UP always starts a fresh PWM period
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            scnt <= 8'd0;
        end else begin
            if (state == ST_IDLE || tick)
                pcnt <= '0;
            else
                pcnt <= pcnt + PERIOD_W'(1);

            if (state_nxt != state || step_ev)
                scnt <= 8'd0;
            else if (tick)
                scnt <= scnt + 8'd1;
        end
    end

    assign busy          = (state != ST_IDLE);
    assign holding       = (state == ST_HOLD);
    assign burstmode_out = holding && burst_r;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Scoreboard bench for pwm_ramp_sequencer: stimulus queues expected duty steps and
// done pulses; a negedge monitor pops and compares whenever the DUT output moves.
module tb_pwm_ramp_sequencer;

    logic        sysclk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] period_in = 16'd0;
    logic [7:0]  target_duty = 8'd0;
    logic [7:0]  step = 8'd0;
    logic [7:0]  periods_per_step = 8'd0;
    logic        burst_req = 1'b0;
    logic        burst_type_in = 1'b0;
    logic [15:0] period_out;
    logic [7:0]  duty_out;
    logic        burstmode_out;
    logic        bursttype_out;
    logic        busy;
    logic        holding;
    logic        done;

    pwm_ramp_sequencer #(.PERIOD_W(16), .DUTY_MAX(100), .MIN_PERIOD(2)) dut (
        .sysclk(sysclk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .period_in(period_in),
        .target_duty(target_duty),
        .step(step),
        .periods_per_step(periods_per_step),
        .burst_req(burst_req),
        .burst_type_in(burst_type_in),
        .period_out(period_out),
        .duty_out(duty_out),
        .burstmode_out(burstmode_out),
        .bursttype_out(bursttype_out),
        .busy(busy),
        .holding(holding),
        .done(done)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        bit is_done;
        int val;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_d(input int v, input int g);
        exp_t e;
        e.is_done = 1'b0;
        e.val     = v;
        e.gap     = g;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.val     = 0;
        e.gap     = 0;
        sb.push_back(e);
    endtask

    // Monitor: a change of duty_out or a done pulse consumes one scoreboard entry.
    logic [7:0] prev_duty = 8'd0;
    logic       prev_busy = 1'b0;
    int         last_ref = 0;
    exp_t       mon_e;

    always @(negedge sysclk) begin
        if (!reset) begin
            last_ref = cyc;
        end else begin
            if (busy && !prev_busy)
                last_ref = cyc;
            if (duty_out !== prev_duty) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_duty: got %0d expected no change (cycle %0d)", duty_out, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_done) begin
                        n_fail++;
                        $display("FAIL duty_order: got duty %0d expected done pulse (cycle %0d)", duty_out, cyc);
                    end else begin
                        chk("duty_val", 32'(duty_out), mon_e.val);
                        if (mon_e.gap != 0)
                            chk("step_gap", cyc - last_ref, mon_e.gap);
                    end
                end
                last_ref = cyc;
            end
            if (done === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (!mon_e.is_done) begin
                        n_fail++;
                        $display("FAIL done_order: got done pulse expected duty %0d (cycle %0d)", mon_e.val, cyc);
                    end
                    chk("done_busy", 32'(busy), 0);
                end
            end
        end
        prev_duty = duty_out;
        prev_busy = busy;
    end

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++)
            @(negedge sysclk);
        @(negedge sysclk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending events expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic do_start(input int per, input int tgt, input int stp, input int pps,
                            input bit br, input bit bt);
        @(negedge sysclk);
        period_in        = 16'(per);
        target_duty      = 8'(tgt);
        step             = 8'(stp);
        periods_per_step = 8'(pps);
        burst_req        = br;
        burst_type_in    = bt;
        start            = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        #1;
    endtask

    task automatic do_stop();
        @(negedge sysclk);
        stop = 1'b1;
        @(negedge sysclk);
        stop = 1'b0;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge sysclk);
        chk("rst_duty", 32'(duty_out), 0);
        chk("rst_period", 32'(period_out), 2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_holding", 32'(holding), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_burstmode", 32'(burstmode_out), 0);
        chk("rst_bursttype", 32'(bursttype_out), 0);
        reset = 1'b1;

        // Ramp to 90 in steps of 10 every 40 cycles, burst requested for HOLD
        for (int d = 10; d <= 90; d += 10) push_d(d, 40);
        do_start(40, 90, 10, 1, 1'b1, 1'b1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_duty0", 32'(duty_out), 0);
        chk("t1_period", 32'(period_out), 40);
        chk("t1_burst_ramp", 32'(burstmode_out), 0);
        wait_drain("t1", 500);
        chk("t1_holding", 32'(holding), 1);
        chk("t1_duty_hold", 32'(duty_out), 90);
        chk("t3_burstmode", 32'(burstmode_out), 1);
        chk("t3_bursttype", 32'(bursttype_out), 1);

        // start during HOLD must not disturb anything
        do_start(7, 20, 3, 1, 1'b0, 1'b0);
        chk("t5_hold_start_duty", 32'(duty_out), 90);
        chk("t5_hold_start_period", 32'(period_out), 40);
        chk("t5_hold_start_holding", 32'(holding), 1);

        push_d(80, 0);
        for (int d = 70; d >= 0; d -= 10) push_d(d, 40);
        push_done();
        do_stop();
        chk("t3_burst_off", 32'(burstmode_out), 0);
        chk("t3_not_holding", 32'(holding), 0);
        chk("t3_busy_down", 32'(busy), 1);
        wait_drain("t3", 500);
        chk("t3_busy_end", 32'(busy), 0);
        chk("t3_period_kept", 32'(period_out), 40);

        // target 95, step 10, two periods per step: last step clamps 90 -> 95
        for (int d = 10; d <= 90; d += 10) push_d(d, 80);
        push_d(95, 80);
        do_start(40, 95, 10, 2, 1'b0, 1'b0);
        wait_drain("t2", 1000);
        chk("t2_holding", 32'(holding), 1);
        chk("t2_burst_off", 32'(burstmode_out), 0);
        push_d(85, 0);
        for (int d = 75; d >= 5; d -= 10) push_d(d, 80);
        push_d(0, 80);
        push_done();
        do_stop();
        wait_drain("t2_down", 1000);

        // target 150 is latched as 100
        push_d(60, 2);
        push_d(100, 2);
        do_start(2, 150, 60, 1, 1'b0, 1'b0);
        wait_drain("t2_clamp", 20);
        chk("t2_clamp_duty", 32'(duty_out), 100);
        chk("t2_clamp_holding", 32'(holding), 1);
        push_d(40, 0);
        push_d(0, 2);
        push_done();
        do_stop();
        wait_drain("t2_clamp_down", 20);

        // stop during RAMP_UP at duty 30
        push_d(10, 40);
        push_d(20, 40);
        push_d(30, 40);
        do_start(40, 90, 10, 1, 1'b0, 1'b0);
        wait_drain("t4_up", 200);
        push_d(20, 40);
        push_d(10, 40);
        push_d(0, 40);
        push_done();
        do_stop();
        chk("t4_busy", 32'(busy), 1);
        chk("t4_duty_at_stop", 32'(duty_out), 30);
        wait_drain("t4_down", 200);

        // period 0 -> 2, step 0 -> 1, pps 0 -> 1
        push_d(1, 2);
        push_d(2, 2);
        push_d(3, 2);
        do_start(0, 3, 0, 0, 1'b0, 1'b0);
        chk("t5_period_min", 32'(period_out), 2);
        wait_drain("t5_up", 20);
        chk("t5_holding", 32'(holding), 1);
        push_d(2, 0);
        push_d(1, 2);
        push_d(0, 2);
        push_done();
        do_stop();
        wait_drain("t5_down", 20);

        // start and stop together in IDLE: stop wins
        @(negedge sysclk);
        period_in = 16'd50;
        target_duty = 8'd40;
        start = 1'b1;
        stop = 1'b1;
        @(negedge sysclk);
        start = 1'b0;
        stop = 1'b0;
        #1;
        chk("t5_startstop_busy", 32'(busy), 0);
        chk("t5_startstop_period", 32'(period_out), 2);

        // target 0 goes straight to HOLD; stop then returns via an empty ramp-down
        do_start(10, 0, 5, 1, 1'b0, 1'b0);
        chk("t5_zero_holding", 32'(holding), 1);
        chk("t5_zero_duty", 32'(duty_out), 0);
        push_done();
        do_stop();
        wait_drain("t5_zero", 20);
        chk("t5_zero_idle", 32'(busy), 0);

        // async reset mid RAMP_UP at duty 50
        for (int d = 10; d <= 50; d += 10) push_d(d, 40);
        do_start(40, 90, 10, 1, 1'b1, 1'b1);
        wait_drain("t6_up", 300);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_duty", 32'(duty_out), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_period", 32'(period_out), 2);
        chk("t6_rst_bursttype", 32'(bursttype_out), 0);
        chk("t6_rst_done", 32'(done), 0);
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        repeat (2) @(negedge sysclk);
        #1;
        chk("t6_no_done", 32'(done), 0);
        push_d(10, 40);
        push_d(20, 40);
        do_start(40, 90, 10, 1, 1'b0, 1'b0);
        wait_drain("t6_restart", 200);
        push_d(10, 40);
        push_d(0, 40);
        push_done();
        do_stop();
        wait_drain("t6_down", 200);
        chk("t6_end_busy", 32'(busy), 0);

        repeat (5) @(negedge sysclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_sequencer.md
Name: pwm_ramp_sequencer

Overview:
- Soft-start/soft-stop controller that sits in front of the PWM generator.
- Drives its period, duty, burstmode and bursttype configuration inputs.
- Ramps duty from 0 up to a target in fixed steps, aligned to PWM period boundaries, then holds it (optionally in burst mode).
- On stop, ramps duty back down to 0.

Parameters:
- PERIOD_W, 16, width of period configuration (sysclk cycles per PWM period).
- DUTY_MAX, 100, maximum legal duty value (percent).
- MIN_PERIOD, 2, smallest period accepted; smaller requests are clamped up to it.

Ports:
- sysclk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a ramp-up.
- stop  input  1  single-cycle request to begin a ramp-down.
- period_in  input  PERIOD_W  requested PWM period, latched on accepted start.
- target_duty  input  8  requested hold duty, latched on accepted start.
- step  input  8  duty increment/decrement per step, latched on accepted start.
- periods_per_step  input  8  PWM periods between steps, latched on accepted start.
- burst_req  input  1  burst mode wanted during HOLD, latched on accepted start.
- burst_type_in  input  1  burst type, latched on accepted start.
- period_out  output  PERIOD_W  period to PWM.
- duty_out  output  8  duty to PWM.
- burstmode_out  output  1  burstmode to PWM.
- bursttype_out  output  1  bursttype to PWM.
- busy  output  1  high in any state other than IDLE.
- holding  output  1  high in HOLD.
- done  output  1  one-cycle pulse when ramp-down reaches 0 and the block returns to IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; duty_out=0; period_out=MIN_PERIOD; burstmode_out=0; bursttype_out=0; busy=0; holding=0; done=0; all counters=0. A reset mid-ramp takes effect immediately; no done pulse is generated.
- Latch on accepted start:
  - period = max(period_in, MIN_PERIOD).
  - target = min(target_duty, DUTY_MAX).
  - step: 0 is treated as 1.
  - periods_per_step: 0 is treated as 1.
- Period counter: pcnt runs 0..period_out-1 in every state except IDLE. tick is asserted when pcnt == period_out-1, and pcnt wraps to 0 on that cycle. pcnt clears to 0 on the cycle entering RAMP_UP.
- Step counter: scnt counts ticks. A step event fires on the tick where scnt == periods_per_step-1; scnt then resets to 0. scnt also resets on every state change.
- All duty_out changes are registered, happen only on step events, and occur on the same edge as the tick.

State machine:
- IDLE:
  - start=1 and stop=0 -> latch config, go to RAMP_UP next cycle. duty_out stays 0; busy=1 from that cycle.
  - If the latched target is 0, go directly to HOLD instead.
  - start and stop in the same cycle -> stop wins; remain IDLE.
  - stop alone -> ignored.
- RAMP_UP:
  - On a step event, duty_out = min(duty_out+step, target); arithmetic is 9-bit internally, with no wrap.
  - When the new duty equals target -> HOLD.
  - stop -> RAMP_DOWN on the next cycle from the current duty_out, with no step that cycle.
- HOLD:
  - duty_out = target; holding=1; burstmode_out=latched burst_req; bursttype_out=latched type.
  - stop -> RAMP_DOWN; burstmode_out returns to 0 on the same edge.
- RAMP_DOWN:
  - On a step event, duty_out = max(duty_out-step, 0), saturating.
  - When duty_out reaches 0 -> IDLE, with done=1 for exactly one cycle (the IDLE-entry cycle) and busy=0.
  - If RAMP_DOWN is entered with duty_out=0 -> IDLE on the next cycle, with a done pulse.
- Input handling while busy:
  - start while busy (any state) -> ignored.
  - New inputs while busy -> ignored; latched values only.
  - stop during RAMP_DOWN -> ignored.
- burstmode_out is 0 in every state except HOLD.
- period_out holds its latched value until the next accepted start, including after returning to IDLE.

Test Plan:
1. period_in=40, target=90, step=10, pps=1, pulse start -> duty_out steps 10,20,...,90, one step every 40 cycles; the first step lands 40 cycles after RAMP_UP entry; HOLD is reached after 360 cycles; holding=1.
2. target=95, step=10, pps=2 -> steps every 80 cycles; the final step is clamped 90->95, then HOLD; target=150 is latched as 100.
3. In HOLD at 90 with burst_req=1, burst_type_in=1 -> burstmode_out=1 and bursttype_out=1. Pulse stop -> burstmode_out=0 next cycle; duty 80,70,...,0 every 40 cycles; done pulses for one cycle on IDLE entry; busy falls.
4. stop while in RAMP_UP at duty 30 -> RAMP_DOWN: 20,10,0, then a done pulse; no further increase occurs.
5. Boundaries:
   - period_in=0 -> period_out=2.
   - step=0 -> step of 1.
   - start+stop together in IDLE -> remains IDLE.
   - start during HOLD -> no change.
6. Assert reset (low) mid RAMP_UP at duty 50 -> all outputs return to reset values asynchronously with no done pulse. A start after release ramps from 0 again.
